// File: rtl/detector_jogada.sv
// Button input conditioning: two-flop synchronizer, press/release debounce FSM,
// one-cycle play pulse and registered play code with a multi-button flag.
module detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic                limpa,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_feita,
   output logic                tem_jogada,
   output logic                multipla,
   output logic [3:0]          db_estado
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [3:0] IDLE         = 4'd0;
   localparam logic [3:0] DEBOUNCE     = 4'd1;
   localparam logic [3:0] REGISTRA     = 4'd2;
   localparam logic [3:0] ESPERA_SOLTA = 4'd3;

   logic [N_BOTOES-1:0] sync1_q, sync2_q;
   logic [N_BOTOES-1:0] cand_q, cand_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;
   logic                multipla_q, multipla_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [3:0]          estado_q, estado_d;
   logic [N_BOTOES-1:0] botoes_s;
   logic                cand_multi;

   assign botoes_s = sync2_q;
   // More than one bit set iff clearing the lowest set bit leaves something.
   assign cand_multi = (cand_q & (cand_q - N_BOTOES'(1))) != '0;

   always_comb begin
      estado_d   = estado_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      jogada_d   = jogada_q;
      multipla_d = multipla_q;

      if (limpa) begin
         jogada_d   = '0;
         multipla_d = 1'b0;
      end

      case (estado_q)
         IDLE: begin
            if (habilita && (botoes_s != '0)) begin
               cand_d   = botoes_s;
               cnt_d    = '0;
               estado_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (botoes_s == '0) begin
               estado_d = IDLE;
            end else if (botoes_s != cand_q) begin
               cand_d = botoes_s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_MAX) begin
               // Load takes priority over a simultaneous limpa.
               jogada_d   = cand_q;
               multipla_d = cand_multi;
               estado_d   = REGISTRA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         REGISTRA: begin
            cnt_d    = '0;
            estado_d = ESPERA_SOLTA;
         end
         ESPERA_SOLTA: begin
            if (botoes_s != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         estado_q   <= IDLE;
         jogada_q   <= '0;
         multipla_q <= 1'b0;
      end else begin
         sync1_q    <= botoes;
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         estado_q   <= estado_d;
         jogada_q   <= jogada_d;
         multipla_q <= multipla_d;
      end
   end

   assign jogada       = jogada_q;
   assign multipla     = multipla_q;
   assign jogada_feita = (estado_q == REGISTRA);
   assign tem_jogada   = |botoes_s;
   assign db_estado    = estado_q;

endmodule
